// File: rtl/bus_master_arbiter_mux.sv
// Round-robin bus arbiter for four masters with a registered one-hot-low grant
// and an owner-selected, strobe-gated mux onto the shared slave-facing bus.
module bus_master_arbiter_mux #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_as_,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_grnt_,
  input  logic              m1_req_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_as_,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_grnt_,
  input  logic              m2_req_,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic              m2_as_,
  input  logic              m2_rw,
  input  logic [DATA_W-1:0] m2_wr_data,
  output logic              m2_grnt_,
  input  logic              m3_req_,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m3_as_,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic              m3_grnt_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data,
  output logic [1:0]        owner
);

  // Handshake: a master pulls req_ low and keeps it low for its whole
  // transfer; it may drive the bus once its grnt_ reads low. Ownership only
  // moves on an edge where the current owner's req_ is high.
  logic [3:0] req_n;
  logic [1:0] owner_q;
  logic [1:0] next_owner;
  logic [3:0] grnt_q;
  logic       found;
  logic [1:0] cand;

  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

  always_comb begin
    next_owner = owner_q;
    found      = 1'b0;
    cand       = owner_q;
    if (req_n[owner_q]) begin
      for (int i = 1; i < 4; i++) begin
        cand = owner_q + 2'(i);
        if (!found && !req_n[cand]) begin
          next_owner = cand;
          found      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q <= 2'd0;
      grnt_q  <= 4'b1110;
    end else begin
      owner_q <= next_owner;
      grnt_q  <= ~(4'b0001 << next_owner);
    end
  end

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign owner    = owner_q;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_as_;
  logic              sel_rw;
  logic [DATA_W-1:0] sel_wr_data;

  always_comb begin
    sel_addr    = m0_addr;
    sel_as_     = m0_as_;
    sel_rw      = m0_rw;
    sel_wr_data = m0_wr_data;
    case (owner_q)
      2'd1: begin
        sel_addr    = m1_addr;
        sel_as_     = m1_as_;
        sel_rw      = m1_rw;
        sel_wr_data = m1_wr_data;
      end
      2'd2: begin
        sel_addr    = m2_addr;
        sel_as_     = m2_as_;
        sel_rw      = m2_rw;
        sel_wr_data = m2_wr_data;
      end
      2'd3: begin
        sel_addr    = m3_addr;
        sel_as_     = m3_as_;
        sel_rw      = m3_rw;
        sel_wr_data = m3_wr_data;
      end
      default: ;
    endcase
  end

  // A parked owner that is not requesting must not be able to start a cycle.
  always_comb begin
    if (req_n[owner_q]) begin
      s_addr    = '0;
      s_as_     = 1'b1;
      s_rw      = 1'b1;
      s_wr_data = '0;
    end else begin
      s_addr    = sel_addr;
      s_as_     = sel_as_;
      s_rw      = sel_rw;
      s_wr_data = sel_wr_data;
    end
  end

endmodule
